// File: rtl/accel_spi_responder.sv
// rtl/accel_spi_responder.sv - SPI mode-0 responder exposing latest X/Y/Z accel sample via byte register map
// SCLK/CS_N/MOSI are oversampled in the clk domain; the sample is frozen into a shadow copy at each CS_N fall.
module accel_spi_responder #(
  parameter logic [7:0] WHO_AM_I    = 8'h33,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  input  logic        sample_valid,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [7:0]  ctrl_reg,
  output logic        drdy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_e;

  // Extra top bit on sclk/cs chains holds the previous synced value for edge detection.
  // cs chain resets low so a CS_N already low at reset release never looks like a fall.
  logic [SYNC_STAGES:0]   sclk_sync_q, cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-1:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-1:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  logic sclk_rise, sclk_fall, cs_rise, cs_fall, mosi_s;
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_sync_q[SYNC_STAGES];
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_sync_q[SYNC_STAGES];
  assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_sync_q[SYNC_STAGES];
  assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_sync_q[SYNC_STAGES];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [6:0]  tx_q, tx_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        miso_q, miso_d, oe_q, oe_d, drdy_q, drdy_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [15:0] live_x_q, live_y_q, live_z_q, live_x_d, live_y_d, live_z_d;
  logic [15:0] shd_x_q, shd_y_q, shd_z_q, shd_x_d, shd_y_d, shd_z_d;

  // Address of the byte loaded at a byte boundary: the command's address, or the next one in a burst.
  logic [6:0] rd_addr;
  logic [7:0] rd_byte;
  assign rd_addr = (state_q == S_CMD) ? {shift_q[5:0], mosi_s} : addr_q + 7'd1;

  always_comb begin
    rd_byte = 8'h00;
    case (rd_addr)
      7'h0F:   rd_byte = WHO_AM_I;
      7'h20:   rd_byte = ctrl_q;
      7'h27:   rd_byte = {7'b0, drdy_q};
      7'h28:   rd_byte = shd_x_q[7:0];
      7'h29:   rd_byte = shd_x_q[15:8];
      7'h2A:   rd_byte = shd_y_q[7:0];
      7'h2B:   rd_byte = shd_y_q[15:8];
      7'h2C:   rd_byte = shd_z_q[7:0];
      7'h2D:   rd_byte = shd_z_q[15:8];
      default: rd_byte = 8'h00;
    endcase
  end

  logic drdy_clr;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    addr_d   = addr_q;
    rw_d     = rw_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    ctrl_d   = ctrl_q;
    shd_x_d  = shd_x_q;
    shd_y_d  = shd_y_q;
    shd_z_d  = shd_z_q;
    drdy_clr = 1'b0;

    if (cs_rise) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cs_fall) begin
          state_d = S_CMD;
          shd_x_d = live_x_q;
          shd_y_d = live_y_q;
          shd_z_d = live_z_q;
          cnt_d   = 3'd0;
          oe_d    = 1'b1;
          miso_d  = 1'b0;
        end
        S_CMD: if (sclk_rise) begin
          shift_d = {shift_q[5:0], mosi_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = S_DATA;
            rw_d    = shift_q[6];
            addr_d  = {shift_q[5:0], mosi_s};
            if (shift_q[6]) begin
              miso_d = rd_byte[7];
              tx_d   = rd_byte[6:0];
            end
          end
        end
        S_DATA: if (sclk_rise) begin
          shift_d = {shift_q[5:0], mosi_s};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_d = addr_q + 7'd1;
            if (rw_q) begin
              drdy_clr = (addr_q == 7'h28);
              miso_d   = rd_byte[7];
              tx_d     = rd_byte[6:0];
            end else if (addr_q == 7'h20) begin
              ctrl_d = {shift_q, mosi_s};
            end
          end
        end else if (sclk_fall && rw_q && cnt_q != 3'd0) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
          miso_d = tx_q[6];
          tx_d   = {tx_q[5:0], 1'b0};
        end
        default: state_d = S_IDLE;
      endcase
    end

    live_x_d = live_x_q;
    live_y_d = live_y_q;
    live_z_d = live_z_q;
    drdy_d   = drdy_q;
    if (sample_valid && ctrl_q[0]) begin
      live_x_d = sample_x;
      live_y_d = sample_y;
      live_z_d = sample_z;
      drdy_d   = 1'b1;
    end else if (drdy_clr) begin
      drdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      tx_q     <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      miso_q   <= 1'b0;
      oe_q     <= 1'b0;
      drdy_q   <= 1'b0;
      ctrl_q   <= 8'h00;
      live_x_q <= '0;
      live_y_q <= '0;
      live_z_q <= '0;
      shd_x_q  <= '0;
      shd_y_q  <= '0;
      shd_z_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      addr_q   <= addr_d;
      rw_q     <= rw_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      drdy_q   <= drdy_d;
      ctrl_q   <= ctrl_d;
      live_x_q <= live_x_d;
      live_y_q <= live_y_d;
      live_z_q <= live_z_d;
      shd_x_q  <= shd_x_d;
      shd_y_q  <= shd_y_d;
      shd_z_q  <= shd_z_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign ctrl_reg    = ctrl_q;
  assign drdy        = drdy_q;

endmodule

// File: tb/tb_accel_spi_responder.sv
// tb/tb_accel_spi_responder.sv - directed table-driven bench for accel_spi_responder
module tb_accel_spi_responder;

  localparam int H = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        sample_valid;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe, drdy;
  logic [7:0]  ctrl_reg;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  accel_spi_responder #(.WHO_AM_I(8'h33), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_x(sample_x), .sample_y(sample_y), .sample_z(sample_z),
    .sample_valid(sample_valid),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .ctrl_reg(ctrl_reg), .drdy(drdy)
  );

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic [7:0] exp_ctrl;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    wait_clk(1);
    spi_cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_high();
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = tx[i];
      wait_clk(H);
      rx[i]    = spi_miso;
      spi_sclk = 1'b1;
      wait_clk(H);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic txn(input logic [7:0] cmd, input logic [7:0] data, output logic [7:0] rx);
    logic [7:0] dummy;
    cs_low();
    xfer(cmd, dummy);
    xfer(data, rx);
    cs_high();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    wait_clk(1);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    wait_clk(1);
    sample_valid = 1'b0;
    wait_clk(1);
  endtask

  vec_t       vecs[12];
  logic [7:0] rx, dummy;
  logic [7:0] exp_burst[6];

  initial begin
    vecs[0]  = '{8'h8F, 8'h00, 8'h33, 8'h00};
    vecs[1]  = '{8'hA0, 8'h00, 8'h00, 8'h00};
    vecs[2]  = '{8'h20, 8'h01, 8'h00, 8'h01};
    vecs[3]  = '{8'hA0, 8'h00, 8'h01, 8'h01};
    vecs[4]  = '{8'h0F, 8'hFF, 8'h00, 8'h01};
    vecs[5]  = '{8'h8F, 8'h00, 8'h33, 8'h01};
    vecs[6]  = '{8'hA7, 8'h00, 8'h00, 8'h01};
    vecs[7]  = '{8'hFF, 8'h00, 8'h00, 8'h01};
    vecs[8]  = '{8'h20, 8'h05, 8'h00, 8'h05};
    vecs[9]  = '{8'h21, 8'h00, 8'h00, 8'h05};
    vecs[10] = '{8'hA0, 8'h00, 8'h05, 8'h05};
    vecs[11] = '{8'h20, 8'h01, 8'h00, 8'h01};
    exp_burst[0] = 8'h34; exp_burst[1] = 8'h12; exp_burst[2] = 8'hCD;
    exp_burst[3] = 8'hAB; exp_burst[4] = 8'h01; exp_burst[5] = 8'h80;

    reset_n = 1'b0;
    sample_x = '0; sample_y = '0; sample_z = '0; sample_valid = 1'b0;
    spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0;
    wait_clk(3);
    chk("reset_miso", {7'b0, spi_miso}, 8'h00);
    chk("reset_oe", {7'b0, spi_miso_oe}, 8'h00);
    chk("reset_ctrl", ctrl_reg, 8'h00);
    chk("reset_drdy", {7'b0, drdy}, 8'h00);
    reset_n = 1'b1;
    wait_clk(6);

    // Register access table
    for (int i = 0; i < 12; i++) begin
      txn(vecs[i].cmd, vecs[i].data, rx);
      if (vecs[i].cmd[7]) chk($sformatf("vec%0d_rd", i), rx, vecs[i].exp_rd);
      chk($sformatf("vec%0d_ctrl", i), ctrl_reg, vecs[i].exp_ctrl);
    end

    // Output enable only inside chip select
    cs_low();
    chk("oe_in_cs", {7'b0, spi_miso_oe}, 8'h01);
    xfer(8'h8F, dummy);
    xfer(8'h00, rx);
    chk("whoami_oe_txn", rx, 8'h33);
    cs_high();
    chk("oe_after_cs", {7'b0, spi_miso_oe}, 8'h00);

    // Six-byte burst of a captured sample; drdy cleared by the X_L read
    pulse_sample(16'h1234, 16'hABCD, 16'h8001);
    chk("drdy_set", {7'b0, drdy}, 8'h01);
    cs_low();
    xfer(8'hA8, dummy);
    for (int i = 0; i < 6; i++) begin
      xfer(8'h00, rx);
      chk($sformatf("burst_b%0d", i), rx, exp_burst[i]);
      if (i == 0) chk("drdy_clr_after_xl", {7'b0, drdy}, 8'h00);
    end
    cs_high();

    // Mid-burst sample does not disturb the shadow copy
    cs_low();
    xfer(8'hA8, dummy);
    xfer(8'h00, rx);
    chk("coh_xl", rx, 8'h34);
    pulse_sample(16'h0002, 16'hABCD, 16'h8001);
    xfer(8'h00, rx);
    chk("coh_xh_old", rx, 8'h12);
    cs_high();
    chk("drdy_midburst_set", {7'b0, drdy}, 8'h01);
    cs_low();
    xfer(8'hA8, dummy);
    xfer(8'h00, rx);
    chk("new_xl", rx, 8'h02);
    xfer(8'h00, rx);
    chk("new_xh", rx, 8'h00);
    cs_high();
    chk("drdy_clr2", {7'b0, drdy}, 8'h00);
    txn(8'h20, 8'h00, rx);
    chk("ctrl_off", ctrl_reg, 8'h00);
    pulse_sample(16'hFFFF, 16'hFFFF, 16'hFFFF);
    chk("drdy_disabled", {7'b0, drdy}, 8'h00);
    txn(8'hA8, 8'h00, rx);
    chk("no_update_xl", rx, 8'h02);

    // Address wrap and burst across STATUS into X_L
    cs_low();
    xfer(8'hFF, dummy);
    xfer(8'h00, rx);
    chk("wrap_7f", rx, 8'h00);
    xfer(8'h00, rx);
    chk("wrap_00", rx, 8'h00);
    cs_high();
    cs_low();
    xfer(8'hA6, dummy);
    xfer(8'h00, rx);
    chk("b26", rx, 8'h00);
    xfer(8'h00, rx);
    chk("b27_status", rx, 8'h00);
    xfer(8'h00, rx);
    chk("b28_xl", rx, 8'h02);
    cs_high();

    // Aborted write and aborted read
    txn(8'h20, 8'h01, rx);
    chk("ctrl_on", ctrl_reg, 8'h01);
    cs_low();
    xfer(8'h20, dummy);
    spi_bits(8'hF0, 4, dummy);
    cs_high();
    chk("partial_write", ctrl_reg, 8'h01);
    pulse_sample(16'h0005, 16'h0000, 16'h0000);
    cs_low();
    xfer(8'hA8, dummy);
    spi_bits(8'h00, 4, dummy);
    cs_high();
    chk("partial_read_drdy", {7'b0, drdy}, 8'h01);

    // Reset mid-read, release with CS_N still low
    cs_low();
    xfer(8'h8F, dummy);
    spi_bits(8'h00, 3, dummy);
    reset_n = 1'b0;
    wait_clk(2);
    chk("rst_mid_oe", {7'b0, spi_miso_oe}, 8'h00);
    chk("rst_mid_miso", {7'b0, spi_miso}, 8'h00);
    chk("rst_mid_ctrl", ctrl_reg, 8'h00);
    chk("rst_mid_drdy", {7'b0, drdy}, 8'h00);
    reset_n = 1'b1;
    wait_clk(4);
    xfer(8'h8F, dummy);
    chk("cs_low_at_release_oe", {7'b0, spi_miso_oe}, 8'h00);
    cs_high();
    txn(8'h8F, 8'h00, rx);
    chk("whoami_after_rst", rx, 8'h33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
